// File: rtl/hazard3_fetch_align_buf.sv
// Prefetch FIFO plus 3-halfword instruction window: re-aligns 32-bit fetch words
// to halfword granularity so decode sees a window starting at the current PC.
module hazard3_fetch_align_buf #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_data,
    input  logic        fetch_err,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic        flush_hw_offs,
    output logic [31:0] cir,
    output logic [1:0]  cir_vld,
    output logic [1:0]  cir_err,
    input  logic [1:0]  cir_use
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   hw_q [3];
    logic [15:0]   hw_d [3];
    logic [15:0]   sh_hw [3];
    logic [2:0]    err_q, err_d, sh_err;
    logic [1:0]    level_q, level_d;
    logic          drop_first_q, drop_first_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [32:0]   fifo_mem_q [DEPTH];

    logic          accept, fifo_empty, refill, pop, push, push_en;
    logic [1:0]    use_eff, lvl_a;
    logic [32:0]   src;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fetch_ready = (count_q != CW'(DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign accept      = fetch_valid && fetch_ready;
    assign cir         = {hw_q[1], hw_q[0]};
    assign cir_err     = err_q[1:0];
    assign cir_vld     = level_q[1] ? 2'd2 : level_q;

    always_comb begin
        use_eff = (cir_use > cir_vld) ? cir_vld : cir_use;
        lvl_a   = level_q - use_eff;

        for (int i = 0; i < 3; i++) begin
            sh_hw[i] = hw_q[i];
        end
        sh_err = err_q;
        case (use_eff)
            2'd1: begin
                sh_hw[0] = hw_q[1];
                sh_hw[1] = hw_q[2];
                sh_err   = {err_q[2], err_q[2:1]};
            end
            2'd2: begin
                sh_hw[0] = hw_q[2];
                sh_err   = {err_q[2:1], err_q[2]};
            end
            default: ;
        endcase

        // The FIFO head always has priority over the bypass path to keep fetch order.
        src     = fifo_empty ? {fetch_err, fetch_data} : fifo_mem_q[rd_ptr_q];
        refill  = (lvl_a <= 2'd1) && (!fifo_empty || accept);
        pop     = refill && !fifo_empty;
        push    = accept && !(refill && fifo_empty);
        push_en = push && !flush;

        for (int i = 0; i < 3; i++) begin
            hw_d[i] = sh_hw[i];
        end
        err_d        = sh_err;
        level_d      = lvl_a;
        drop_first_d = drop_first_q;

        if (refill) begin
            if (drop_first_q) begin
                if (lvl_a[0]) begin
                    hw_d[1]  = src[31:16];
                    err_d[1] = src[32];
                end else begin
                    hw_d[0]  = src[31:16];
                    err_d[0] = src[32];
                end
                level_d      = lvl_a + 2'd1;
                drop_first_d = 1'b0;
            end else begin
                if (lvl_a[0]) begin
                    hw_d[1]  = src[15:0];
                    hw_d[2]  = src[31:16];
                    err_d[1] = src[32];
                    err_d[2] = src[32];
                end else begin
                    hw_d[0]  = src[15:0];
                    hw_d[1]  = src[31:16];
                    err_d[0] = src[32];
                    err_d[1] = src[32];
                end
                level_d = lvl_a + 2'd2;
            end
        end

        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        if (flush) begin
            level_d      = 2'd0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            drop_first_d = flush_hw_offs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= 16'h0;
            end
            err_q        <= 3'b0;
            level_q      <= 2'd0;
            drop_first_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= hw_d[i];
            end
            err_q        <= err_d;
            level_q      <= level_d;
            drop_first_q <= drop_first_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 33'h0;
            end
        end else if (push_en) begin
            fifo_mem_q[wr_ptr_q] <= {fetch_err, fetch_data};
        end
    end

endmodule

// File: tb/tb_hazard3_fetch_align_buf.sv
// Self-checking bench: directed scenarios plus random traffic, compared against a
// queue-based model of the halfword stream and the word prefetch buffer.
module tb_hazard3_fetch_align_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        flush_hw_offs;
    logic [31:0] cir;
    logic [1:0]  cir_vld;
    logic [1:0]  cir_err;
    logic [1:0]  cir_use;

    int checks = 0;
    int errors = 0;

    // Model state: halfwords visible to decode, and whole words still queued behind them.
    logic [16:0] mq [$];
    logic [32:0] mf [$];
    bit          mdrop;

    hazard3_fetch_align_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_data   (fetch_data),
        .fetch_err    (fetch_err),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .flush_hw_offs(flush_hw_offs),
        .cir          (cir),
        .cir_vld      (cir_vld),
        .cir_err      (cir_err),
        .cir_use      (cir_use)
    );

    always #5 clk = ~clk;

    function automatic int mvld();
        return (mq.size() >= 2) ? 2 : mq.size();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mf.delete();
        mdrop = 1'b0;
    endtask

    task automatic modelStep();
        bit          acc;
        bit          fifo_was_empty;
        logic [32:0] w;
        acc = fetch_valid && (mf.size() < DEPTH);
        if (flush) begin
            mq.delete();
            mf.delete();
            mdrop = flush_hw_offs;
        end else begin
            for (int k = 0; k < int'(cir_use); k++) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end
            fifo_was_empty = (mf.size() == 0);
            if (mq.size() <= 1 && (!fifo_was_empty || acc)) begin
                w = fifo_was_empty ? {fetch_err, fetch_data} : mf.pop_front();
                if (mdrop) begin
                    mq.push_back({w[32], w[31:16]});
                    mdrop = 1'b0;
                end else begin
                    mq.push_back({w[32], w[15:0]});
                    mq.push_back({w[32], w[31:16]});
                end
                if (acc && !fifo_was_empty) mf.push_back({fetch_err, fetch_data});
            end else if (acc) begin
                mf.push_back({fetch_err, fetch_data});
            end
        end
    endtask

    task automatic checkOutput();
        check("fetch_ready", 32'(fetch_ready), 32'(mf.size() < DEPTH));
        check("cir_vld", 32'(cir_vld), 32'(mvld()));
        if (mvld() >= 1) begin
            check("cir_hw0", 32'(cir[15:0]), 32'(mq[0][15:0]));
            check("cir_err0", 32'(cir_err[0]), 32'(mq[0][16]));
        end
        if (mvld() == 2) begin
            check("cir_hw1", 32'(cir[31:16]), 32'(mq[1][15:0]));
            check("cir_err1", 32'(cir_err[1]), 32'(mq[1][16]));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic e,
                                 input logic [1:0] u, input logic f, input logic o);
        fetch_valid   = v;
        fetch_data    = d;
        fetch_err     = e;
        cir_use       = u;
        flush         = f;
        flush_hw_offs = o;
        check("use_legal", 32'(cir_use <= cir_vld), 32'd1);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic checkResetState();
        check("rst_cir", cir, 32'h0);
        check("rst_vld", 32'(cir_vld), 32'd0);
        check("rst_err", 32'(cir_err), 32'd0);
        check("rst_ready", 32'(fetch_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_data = '0; fetch_err = 1'b0;
        cir_use = 2'd0; flush = 1'b0; flush_hw_offs = 1'b0;
        modelReset();
        #12;
        checkResetState();
        rst_n = 1'b1;

        $display("[TB] single word bypass and consume");
        applyStimulus(1'b1, 32'h45010505, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t1_cir", cir, 32'h45010505);
        check("t1_vld", 32'(cir_vld), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0);
        check("t1_hw0", 32'(cir[15:0]), 32'h4501);
        check("t1_vld1", 32'(cir_vld), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);

        $display("[TB] halfword realignment across words");
        applyStimulus(1'b1, 32'h12344581, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hCAFE5678, 1'b0, 2'd1, 1'b0, 1'b0);
        check("t2_cir", cir, 32'h56781234);
        check("t2_vld", 32'(cir_vld), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        check("t2_hw0", 32'(cir[15:0]), 32'hCAFE);

        $display("[TB] flush to halfword-offset target");
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hAAAABBBB, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_vld", 32'(cir_vld), 32'd1);
        check("t3_hw0", 32'(cir[15:0]), 32'hAAAA);
        applyStimulus(1'b1, 32'h11112222, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_cir", cir, 32'h2222AAAA);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);

        $display("[TB] fill to capacity then drain");
        applyStimulus(1'b1, 32'h00020001, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00040003, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t4_ready2", 32'(fetch_ready), 32'd1);
        applyStimulus(1'b1, 32'h00060005, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t4_ready3", 32'(fetch_ready), 32'd0);
        applyStimulus(1'b1, 32'h00080007, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 2'(mvld()), 1'b0, 1'b0);
        end
        check("t4_empty", 32'(cir_vld), 32'd0);

        $display("[TB] flush discards same-cycle fetch");
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b0);
        check("t5_vld", 32'(cir_vld), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t5_vld2", 32'(cir_vld), 32'd0);

        $display("[TB] bus error propagation");
        applyStimulus(1'b1, 32'h00000013, 1'b1, 2'd0, 1'b0, 1'b0);
        check("t6_err", 32'(cir_err), 32'd3);
        applyStimulus(1'b1, 32'h00000001, 1'b0, 2'd1, 1'b0, 1'b0);
        check("t6_err2", 32'(cir_err), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 7) == 0,
                          2'($urandom_range(0, mvld())), $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] asynchronous reset mid-operation");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 7) == 0,
                          2'($urandom_range(0, mvld())), $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
